renkon_serial_drain: RTL and testbench
======================================

Name: renkon_serial_drain

Overview:
Read-side streamer for the renkon serial output memory.
- On a start pulse, sequentially reads words 0..total-1 from the memory's read port and emits them as a valid/ready stream toward the ninjin output path.
- Hides the memory's one-cycle read latency with a 2-entry skid buffer, so a continuously-ready sink sees one word per cycle.

Parameters:
- DWIDTH, 16, data word width; must match the serial memory's word width.
- OUTSIZE, 8, address width of the serial memory; also the width of total.
- WORDS, 150, physical depth of the memory; total is clamped to this value.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a drain; ignored unless the FSM is in IDLE.
- total  input  OUTSIZE  number of words to drain; sampled when start is accepted.
- mem_addr  output  OUTSIZE  read address to the serial memory.
- mem_rdata  input signed  DWIDTH  memory read data; valid the cycle after mem_addr is presented.
- out_data  output signed  DWIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the sink.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last word has been handshaked.

Behaviour:
- Reset values: mem_addr=0, out_valid=0, out_data=0, busy=0, done=0. Reset also empties the FIFO, clears the in-flight flag and returns the FSM to IDLE.
- Reset mid-drain aborts immediately: no done pulse, and no further words are emitted.
- FSM states:
  - IDLE: start=1 latches n=min(total,WORDS), clears the issue counter and emit counter, and goes to RUN. If n==0, go to FIN instead.
  - RUN: issue reads and emit words as described below. Leave for FIN on the cycle the n-th word handshakes.
  - FIN: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Read issue:
  - A read is issued in a cycle when issued<n and (fifo_count + inflight + issue_this_cycle_guard) <= 1, counted after this cycle's pop.
  - Issuing drives mem_addr=issued, sets inflight=1 for the next cycle, and increments issued.
  - When no read is issued, mem_addr holds its last value; it is never driven to an out-of-range address.
- Capture: the cycle after a read is issued, mem_rdata is pushed into the 2-entry FIFO. Capture is unconditional; the issue rule guarantees the FIFO has space.
- Stream output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A handshake (out_valid & out_ready) pops the head and increments emitted.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop in the same cycle keeps the FIFO count unchanged; order is preserved.
- Throughput and latency:
  - With out_ready held at 1, the first out_valid is asserted 2 cycles after start is sampled (issue, then capture).
  - After that, one word per cycle; done follows 1 cycle after the last handshake.
- Backpressure: out_ready=0 for any duration loses no words and duplicates none; issue stalls once FIFO plus in-flight equals 2.
- start during RUN or FIN is ignored, and total is not resampled.
- busy=1 in RUN only. The writer side of the memory must not write while busy; that is a system-level rule, and this block does not check it.
- Counters issued and emitted are OUTSIZE+1 bits wide, so n=2^OUTSIZE-1 does not overflow.

Decomposition:
- Shared definitions (DWIDTH, OUTSIZE) stay in the existing ninjin/renkon include headers.
- FSM state encodings (IDLE/RUN/FIN) are local parameters in this module.
- One natural sub-module: renkon_skid_fifo2, a 2-entry synchronous FIFO with push, pop, count, head and synchronous active-high reset. It is reusable for other latency-hiding readers.

Test Plan:
- Memory preloaded with mem[i]=i*3; start with total=5, out_ready=1 -> stream 0,3,6,9,12 on 5 consecutive cycles; first out_valid 2 cycles after start; done 1 cycle after the 12 is handshaked; mem_addr sequence 0..4.
- total=6, out_ready toggling 1,0,0,1,0,1... -> exactly six words in order mem[0..5]; out_data stable while stalled; no address issued beyond 5.
- total=0 -> no out_valid; done pulses in the cycle after start; busy never asserts.
- total=200 with WORDS=150 -> exactly 150 words emitted, last = mem[149].
- rst asserted after 3 of 10 words -> all outputs at reset values the next cycle, no done; a fresh start with total=2 emits mem[0], mem[1].
- start re-pulsed with total=1 in the middle of a drain with total=4 -> ignored; exactly 4 words and one done.

Source files
------------

// File: rtl/renkon_serial_drain_pkg.sv
// Shared definitions for the renkon serial-output drain path.
//   DEF_DWIDTH  : default data word width of the serial memory
//   DEF_OUTSIZE : default address width of the serial memory (also width of total)
//   DEF_WORDS   : default physical depth of the serial memory
//   issue_allowed() : read-issue gate for the 2-entry skid FIFO
package renkon_serial_drain_pkg;

  localparam int DEF_DWIDTH  = 16;
  localparam int DEF_OUTSIZE = 8;
  localparam int DEF_WORDS   = 150;

  // A read issued now lands in the FIFO two edges later. Allow it only if the
  // FIFO occupancy after this cycle's pop, plus the read already in flight,
  // leaves room for one more word.
  function automatic logic issue_allowed(input logic [1:0] count,
                                         input logic       pop,
                                         input logic       inflight);
    return (int'(count) - int'(pop) + int'(inflight)) <= 1;
  endfunction

endpackage

// File: rtl/renkon_serial_drain_if.sv
// Valid/ready word stream from the renkon serial drain toward the ninjin
// output path.
//   out_data  : signed stream word
//   out_valid : word on out_data is valid
//   out_ready : sink accepts the word this cycle
// master = drain side, slave = sink side.
interface renkon_serial_drain_if
  import renkon_serial_drain_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) ();

  logic signed [DWIDTH-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/renkon_skid_fifo2.sv
// Two-entry synchronous FIFO used to hide a one-cycle memory read latency.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din at the tail (dropped only if full without a pop)
//   pop      : remove the head (ignored when empty)
//   head     : current head word
//   count    : occupancy, 0..2
// Push and pop in the same cycle keep the count and preserve order.
module renkon_skid_fifo2
  import renkon_serial_drain_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic signed [DWIDTH-1:0] din,
  input  logic                     pop,
  output logic signed [DWIDTH-1:0] head,
  output logic [1:0]               count
);

  logic signed [DWIDTH-1:0] slot_q [2];
  logic                     rd_ptr_q;
  logic                     wr_ptr_q;
  logic [1:0]               count_q;
  logic                     do_push;
  logic                     do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two data slots are reset too; they are only two words and
      // the head must read as zero straight out of reset.
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= din;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = slot_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/renkon_serial_drain.sv
// Read-side streamer for the renkon serial output memory.
// On start, reads words 0..n-1 (n = min(total, WORDS)) and emits them on a
// valid/ready stream; a 2-entry skid FIFO hides the one-cycle read latency so
// an always-ready sink sees one word per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, accepted only in IDLE
//   total      : word count, sampled when start is accepted
//   mem_addr   : read address to the serial memory
//   mem_rdata  : read data, valid the cycle after mem_addr is presented
//   out_if     : master side of the output stream
//   busy       : high while draining (RUN)
//   done       : one-cycle pulse after the last handshake
module renkon_serial_drain
  import renkon_serial_drain_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int OUTSIZE = DEF_OUTSIZE,
  parameter int WORDS   = DEF_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OUTSIZE-1:0]       total,
  output logic [OUTSIZE-1:0]       mem_addr,
  input  logic signed [DWIDTH-1:0] mem_rdata,
  renkon_serial_drain_if.master    out_if,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // Counters are one bit wider than total so n = 2^OUTSIZE-1 cannot wrap.
  localparam logic [OUTSIZE:0] ONE     = (OUTSIZE+1)'(1);
  localparam logic [OUTSIZE:0] WORDS_W = (OUTSIZE+1)'(WORDS);

  logic [1:0]               state_q;
  logic [OUTSIZE:0]         n_q;
  logic [OUTSIZE:0]         issued_q;
  logic [OUTSIZE:0]         emitted_q;
  logic [OUTSIZE-1:0]       addr_q;
  logic                     inflight_q;
  logic [OUTSIZE:0]         total_ext;
  logic [OUTSIZE:0]         n_start;
  logic [1:0]               fifo_count;
  logic signed [DWIDTH-1:0] fifo_head;
  logic                     hs;
  logic                     issue;

  // NOTE: every variable written in an always_comb gets a value on every
  // path, otherwise synthesis infers a latch.
  always_comb begin
    total_ext = {1'b0, total};
    n_start   = total_ext;
    if (total_ext > WORDS_W) begin
      n_start = WORDS_W;
    end
  end

  assign out_if.out_valid = (fifo_count != 2'd0);
  assign out_if.out_data  = fifo_head;
  assign hs               = out_if.out_valid & out_if.out_ready;

  assign issue = (state_q == RUN) && (issued_q < n_q) &&
                 issue_allowed(fifo_count, hs, inflight_q);

  // The memory registers the address at the next edge, so the issued address
  // is presented combinationally; otherwise the last address is held.
  assign mem_addr = issue ? issued_q[OUTSIZE-1:0] : addr_q;

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      // Data for a read issued this cycle arrives next cycle and is pushed then.
      inflight_q <= issue;
      if (issue) begin
        issued_q <= issued_q + ONE;
        addr_q   <= issued_q[OUTSIZE-1:0];
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q       <= n_start;
            issued_q  <= '0;
            emitted_q <= '0;
            state_q   <= (n_start == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (hs) begin
            emitted_q <= emitted_q + ONE;
            if (emitted_q == n_q - ONE) begin
              state_q <= FIN;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  renkon_skid_fifo2 #(
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (mem_rdata),
    .pop   (hs),
    .head  (fifo_head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_renkon_serial_drain.sv
// Directed bench for renkon_serial_drain: memory model mem[i] = i*3, inputs
// driven on the falling edge, DUT outputs checked on the falling edge, and
// handshakes/done pulses collected on the rising edge.
module tb_renkon_serial_drain;

  localparam int DWIDTH  = 16;
  localparam int OUTSIZE = 8;
  localparam int WORDS   = 150;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [OUTSIZE-1:0]       total;
  logic [OUTSIZE-1:0]       mem_addr;
  logic signed [DWIDTH-1:0] mem_rdata;
  logic                     busy;
  logic                     done;

  renkon_serial_drain_if #(.DWIDTH(DWIDTH)) out_if ();

  renkon_serial_drain #(
    .DWIDTH  (DWIDTH),
    .OUTSIZE (OUTSIZE),
    .WORDS   (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .total     (total),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_if    (out_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  logic signed [DWIDTH-1:0] mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = DWIDTH'(i * 3);
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    mem_rdata <= (int'(mem_addr) < WORDS) ? mem[mem_addr] : '0;
  end

  // Collector of accepted words, done pulses, busy and highest address.
  logic signed [DWIDTH-1:0] got [$];
  int done_cnt;
  int busy_seen;
  int max_addr;
  always @(posedge clk) begin
    if (out_if.out_valid && out_if.out_ready) got.push_back(out_if.out_data);
    if (done) done_cnt++;
    if (busy) busy_seen++;
    if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    got.delete();
    done_cnt  = 0;
    busy_seen = 0;
    max_addr  = 0;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    total = OUTSIZE'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits on the falling edge for done, bounded; ends one cycle after done.
  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check(tag, (k < budget) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    total = '0;
    out_if.out_ready = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_valid", out_if.out_valid, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // 1: total=5, always ready, cycle-exact timing.
    clear_stats();
    @(negedge clk);
    out_if.out_ready = 1'b1;
    total = 8'd5;
    start = 1'b1;
    @(negedge clk);                     // start sampled at previous edge
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_addr0", mem_addr, 0);
    check("t1_valid_c1", out_if.out_valid, 0);
    @(negedge clk);
    check("t1_addr1", mem_addr, 1);
    check("t1_valid_c2", out_if.out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_valid", out_if.out_valid, 1);
      check("t1_data", out_if.out_data, i * 3);
      check("t1_done_early", done, 0);
      if (i < 3) check("t1_addr", mem_addr, i + 2);
    end
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_fin", busy, 0);
    check("t1_valid_fin", out_if.out_valid, 0);
    @(negedge clk);
    check("t1_done_once", done, 0);
    check("t1_count", got.size(), 5);
    check("t1_maxaddr", max_addr, 4);

    // 2: total=6 with ready pattern 1,0,0,1,0,1 repeating; data must hold.
    clear_stats();
    pulse_start(6);
    begin
      logic [5:0] pat;
      logic       pv, pr;
      logic signed [DWIDTH-1:0] pd;
      int k;
      pat = 6'b101001;                  // bit k is the ready value of step k
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (k = 0; k < 80; k++) begin
        if (done) break;
        if (pv && !pr) begin
          check("t2_hold_valid", out_if.out_valid, 1);
          check("t2_hold_data", out_if.out_data, pd);
        end
        out_if.out_ready = pat[k % 6];
        pv = out_if.out_valid;
        pr = out_if.out_ready;
        pd = out_if.out_data;
        @(negedge clk);
      end
      check("t2_timeout", (k < 80) ? 1 : 0, 1);
    end
    @(negedge clk);
    out_if.out_ready = 1'b1;
    check("t2_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_data", (i < got.size()) ? got[i] : -1, i * 3);
    check("t2_maxaddr", max_addr, 5);
    check("t2_done_cnt", done_cnt, 1);

    // 3: total=0 -> immediate done, no words, never busy.
    clear_stats();
    pulse_start(0);
    check("t3_done", done, 1);
    check("t3_valid", out_if.out_valid, 0);
    @(negedge clk);
    check("t3_done_once", done, 0);
    check("t3_busy_seen", busy_seen, 0);
    check("t3_count", got.size(), 0);

    // 4: total=200 clamps to 150 words.
    clear_stats();
    pulse_start(200);
    wait_done("t4_timeout", 400);
    check("t4_count", got.size(), 150);
    check("t4_last", (got.size() == 150) ? got[149] : -1, 447);
    check("t4_maxaddr", max_addr, 149);

    // 5: reset after 3 of 10 words, then a fresh drain of 2.
    clear_stats();
    pulse_start(10);
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        if (got.size() >= 3) break;
        @(negedge clk);
      end
      check("t5_wait3", got.size(), 3);
    end
    rst = 1'b1;
    out_if.out_ready = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", out_if.out_valid, 0);
    check("t5_rst_data", out_if.out_data, 0);
    check("t5_rst_addr", mem_addr, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    rst = 1'b0;
    got.delete();
    out_if.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_words", got.size(), 0);
    check("t5_no_done", done_cnt, 0);
    pulse_start(2);
    wait_done("t5_timeout", 20);
    check("t5_count", got.size(), 2);
    check("t5_w0", (got.size() > 0) ? got[0] : -1, 0);
    check("t5_w1", (got.size() > 1) ? got[1] : -1, 3);

    // 6: start re-pulsed mid-drain is ignored.
    clear_stats();
    pulse_start(4);
    total = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_timeout", 20);
    repeat (3) @(negedge clk);
    check("t6_count", got.size(), 4);
    check("t6_last", (got.size() == 4) ? got[3] : -1, 9);
    check("t6_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
